// File: rtl/param_alu_pkg.sv
// Shared opcode and flag types for the pipelined ALU and its combinational core.
package param_alu_pkg;

  localparam int OP_W = 3;

  typedef enum logic [OP_W-1:0] {
    OP_ADD = 3'd0,
    OP_SUB = 3'd1,
    OP_AND = 3'd2,
    OP_OR  = 3'd3,
    OP_XOR = 3'd4,
    OP_GT  = 3'd5,
    OP_ACC = 3'd6,
    OP_CLR = 3'd7
  } op_e;

  typedef struct packed {
    logic c;
    logic z;
    logic v;
  } flags_t;

endpackage

// File: rtl/alu_core.sv
// Combinational ALU: result, flags and next accumulator value; zero latency, no handshake.
// Carry/overflow come from the unclamped result, zero flag from the value actually returned.
module alu_core
  import param_alu_pkg::*;
#(
  parameter int WIDTH = 4,
  parameter bit SAT   = 1'b0
) (
  input  op_e              op_i,
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  input  logic [WIDTH-1:0] acc_i,
  output logic [WIDTH-1:0] y_o,
  output logic [WIDTH-1:0] acc_next_o,
  output flags_t           flags_o
);

  localparam int MSB = WIDTH - 1;

  logic [WIDTH:0] add_w;
  logic [WIDTH:0] sub_w;
  logic [WIDTH:0] acc_w;

  assign add_w = {1'b0, a_i} + {1'b0, b_i};
  assign sub_w = {1'b0, a_i} - {1'b0, b_i};
  assign acc_w = {1'b0, acc_i} + {1'b0, a_i};

  always_comb begin
    y_o        = '0;
    acc_next_o = acc_i;
    flags_o    = '0;
    case (op_i)
      OP_ADD: begin
        flags_o.c = add_w[WIDTH];
        flags_o.v = (a_i[MSB] == b_i[MSB]) && (add_w[MSB] != a_i[MSB]);
        y_o       = (SAT && add_w[WIDTH]) ? '1 : add_w[MSB:0];
      end
      OP_SUB: begin
        // Top bit of the zero-extended difference is the borrow (a < b).
        flags_o.c = sub_w[WIDTH];
        flags_o.v = (a_i[MSB] != b_i[MSB]) && (sub_w[MSB] != a_i[MSB]);
        y_o       = (SAT && sub_w[WIDTH]) ? '0 : sub_w[MSB:0];
      end
      OP_AND: y_o = a_i & b_i;
      OP_OR:  y_o = a_i | b_i;
      OP_XOR: y_o = a_i ^ b_i;
      OP_GT:  y_o = (a_i > b_i) ? '1 : '0;
      OP_ACC: begin
        flags_o.c  = acc_w[WIDTH];
        flags_o.v  = (acc_i[MSB] == a_i[MSB]) && (acc_w[MSB] != acc_i[MSB]);
        y_o        = (SAT && acc_w[WIDTH]) ? '1 : acc_w[MSB:0];
        acc_next_o = y_o;
      end
      OP_CLR: begin
        y_o        = '0;
        acc_next_o = '0;
      end
      default: ;
    endcase
    flags_o.z = (y_o == '0);
  end

endmodule

// File: rtl/param_alu_pipe.sv
// Two-stage ALU pipe (operand register, result register); result valid two edges after accept.
// Stages advance when empty or draining; in_ready = !s1_vld || s2 advancing, so out_ready stalls both.
module param_alu_pipe
  import param_alu_pkg::*;
#(
  parameter int WIDTH = 4,
  parameter bit SAT   = 1'b0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [OP_W-1:0]  in_op,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_y,
  output logic             out_c,
  output logic             out_z,
  output logic             out_v
);

  logic             s1_vld_q, s1_vld_d;
  op_e              s1_op_q, s1_op_d;
  logic [WIDTH-1:0] s1_a_q, s1_a_d;
  logic [WIDTH-1:0] s1_b_q, s1_b_d;
  logic             s2_vld_q, s2_vld_d;
  logic [WIDTH-1:0] y_q, y_d;
  flags_t           flags_q, flags_d;
  logic [WIDTH-1:0] acc_q, acc_d;

  logic             s2_adv;
  logic [WIDTH-1:0] core_y;
  logic [WIDTH-1:0] core_acc_next;
  flags_t           core_flags;

  alu_core #(
    .WIDTH (WIDTH),
    .SAT   (SAT)
  ) u_core (
    .op_i       (s1_op_q),
    .a_i        (s1_a_q),
    .b_i        (s1_b_q),
    .acc_i      (acc_q),
    .y_o        (core_y),
    .acc_next_o (core_acc_next),
    .flags_o    (core_flags)
  );

  assign s2_adv   = !s2_vld_q || out_ready;
  assign in_ready = !s1_vld_q || s2_adv;

  always_comb begin
    s1_vld_d = s1_vld_q;
    s1_op_d  = s1_op_q;
    s1_a_d   = s1_a_q;
    s1_b_d   = s1_b_q;
    s2_vld_d = s2_vld_q;
    y_d      = y_q;
    flags_d  = flags_q;
    acc_d    = acc_q;
    if (in_ready) begin
      s1_vld_d = in_valid;
      if (in_valid) begin
        s1_op_d = op_e'(in_op);
        s1_a_d  = in_a;
        s1_b_d  = in_b;
      end
    end
    // acc commits only as its command enters stage 2, so chained ACCs see each other.
    if (s2_adv) begin
      s2_vld_d = s1_vld_q;
      if (s1_vld_q) begin
        y_d     = core_y;
        flags_d = core_flags;
        acc_d   = core_acc_next;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_vld_q <= 1'b0;
      s1_op_q  <= OP_ADD;
      s1_a_q   <= '0;
      s1_b_q   <= '0;
      s2_vld_q <= 1'b0;
      y_q      <= '0;
      flags_q  <= '0;
      acc_q    <= '0;
    end else begin
      s1_vld_q <= s1_vld_d;
      s1_op_q  <= s1_op_d;
      s1_a_q   <= s1_a_d;
      s1_b_q   <= s1_b_d;
      s2_vld_q <= s2_vld_d;
      y_q      <= y_d;
      flags_q  <= flags_d;
      acc_q    <= acc_d;
    end
  end

  assign out_valid = s2_vld_q;
  assign out_y     = y_q;
  assign out_c     = flags_q.c;
  assign out_z     = flags_q.z;
  assign out_v     = flags_q.v;

endmodule

// File: tb/tb_param_alu_pipe.sv
// Scoreboard bench: wrapping (SAT=0) and saturating (SAT=1) pipes share one command stream.
module tb_param_alu_pipe;
  localparam int W = 4;
  localparam int M = 1 << W;
  localparam int H = M / 2;

  logic         clk = 1'b0;
  logic         rst_n, in_valid, out_ready;
  logic [2:0]   in_op;
  logic [W-1:0] in_a, in_b;
  logic         in_ready0, in_ready1, out_valid0, out_valid1;
  logic [W-1:0] y0, y1;
  logic         c0, z0, v0, c1, z1, v1;

  always #5 clk = ~clk;

  param_alu_pipe #(.WIDTH(W), .SAT(1'b0)) dut0 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready0),
    .in_op(in_op), .in_a(in_a), .in_b(in_b), .out_valid(out_valid0),
    .out_ready(out_ready), .out_y(y0), .out_c(c0), .out_z(z0), .out_v(v0)
  );

  param_alu_pipe #(.WIDTH(W), .SAT(1'b1)) dut1 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready1),
    .in_op(in_op), .in_a(in_a), .in_b(in_b), .out_valid(out_valid1),
    .out_ready(out_ready), .out_y(y1), .out_c(c1), .out_z(z1), .out_v(v1)
  );

  int n_chk = 0;
  int n_fail = 0;
  int exp_q0[$], exp_q1[$], got0[$], got1[$];
  int acc_m0 = 0, acc_m1 = 0;
  int na0, na1, p0, p1, held0, held1;
  bit prev_stall = 1'b0;
  bit rdone = 1'b0;
  int dir0[9], dir1[9];

  task automatic chk(input string nm, input int act, input int req);
    n_chk++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: actual %0d required %0d", nm, act, req);
    end
  endtask

  // Results are encoded as y*8 + c*4 + z*2 + v for compact comparison.
  function automatic int e(input int y, input int c, input int z, input int v);
    return y * 8 + c * 4 + z * 2 + v;
  endfunction

  function automatic int pk(input logic [W-1:0] y, input logic c, input logic z, input logic v);
    return int'(y) * 8 + int'(c) * 4 + int'(z) * 2 + int'(v);
  endfunction

  function automatic int sgn(input int x);
    return (x >= H) ? x - M : x;
  endfunction

  function automatic int model(input int op, input int a, input int b, input bit sat,
                               input int acc, output int nacc);
    int s, raw, sv, y;
    bit c, v;
    c = 1'b0; v = 1'b0; y = 0; nacc = acc;
    case (op)
      0: begin
        s = a + b; c = (s >= M); raw = s % M; sv = sgn(a) + sgn(b);
        v = (sv < -H) || (sv >= H); y = (sat && c) ? M - 1 : raw;
      end
      1: begin
        c = (a < b); raw = (a - b + M) % M; sv = sgn(a) - sgn(b);
        v = (sv < -H) || (sv >= H); y = (sat && c) ? 0 : raw;
      end
      2: y = a & b;
      3: y = a | b;
      4: y = a ^ b;
      5: y = (a > b) ? M - 1 : 0;
      6: begin
        s = acc + a; c = (s >= M); raw = s % M; sv = sgn(acc) + sgn(a);
        v = (sv < -H) || (sv >= H); y = (sat && c) ? M - 1 : raw; nacc = y;
      end
      7: begin y = 0; nacc = 0; end
      default: ;
    endcase
    return e(y, int'(c), (y == 0) ? 1 : 0, int'(v));
  endfunction

  // Monitor: samples at negedge, between drive (posedge+1) and the next transfer edge.
  always @(negedge clk) begin
    if (!rst_n) begin
      prev_stall = 1'b0;
    end else begin
      p0 = pk(y0, c0, z0, v0);
      p1 = pk(y1, c1, z1, v1);
      if (prev_stall) begin
        chk("stall_hold0", out_valid0 ? p0 : -1, held0);
        chk("stall_hold1", out_valid1 ? p1 : -1, held1);
      end
      if (in_valid && in_ready0) begin
        exp_q0.push_back(model(int'(in_op), int'(in_a), int'(in_b), 1'b0, acc_m0, na0));
        acc_m0 = na0;
      end
      if (in_valid && in_ready1) begin
        exp_q1.push_back(model(int'(in_op), int'(in_a), int'(in_b), 1'b1, acc_m1, na1));
        acc_m1 = na1;
      end
      if (out_valid0 && out_ready) begin
        if (exp_q0.size() == 0) chk("unexpected_out0", p0, -1);
        else chk("result0", p0, exp_q0.pop_front());
        got0.push_back(p0);
      end
      if (out_valid1 && out_ready) begin
        if (exp_q1.size() == 0) chk("unexpected_out1", p1, -1);
        else chk("result1", p1, exp_q1.pop_front());
        got1.push_back(p1);
      end
      prev_stall = out_valid0 && !out_ready;
      held0 = p0;
      held1 = p1;
    end
  end

  task automatic send(input int op, input int a, input int b);
    int t;
    bit ok;
    in_valid = 1'b1;
    in_op = op[2:0];
    in_a = a[W-1:0];
    in_b = b[W-1:0];
    t = 0; ok = 1'b0;
    while (!ok && t < 200) begin
      @(negedge clk);
      ok = in_ready0;
      @(posedge clk);
      #1;
      t++;
    end
    if (!ok) chk("send_timeout", 0, 1);
    in_valid = 1'b0;
  endtask

  task automatic drain();
    int t;
    out_ready = 1'b1;
    t = 0;
    while ((exp_q0.size() != 0 || exp_q1.size() != 0) && t < 100) begin
      @(posedge clk);
      #1;
      t++;
    end
    chk("drain_done", exp_q0.size() + exp_q1.size(), 0);
  endtask

  task automatic clear_logs();
    got0.delete();
    got1.delete();
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; in_op = '0; in_a = '0; in_b = '0; out_ready = 1'b0;
    #12;
    chk("rst_in_ready", int'(in_ready0), 1);
    chk("rst_out_valid0", int'(out_valid0), 0);
    chk("rst_out_valid1", int'(out_valid1), 0);
    chk("rst_outputs0", pk(y0, c0, z0, v0), 0);
    chk("rst_acc0", int'(dut0.acc_q), 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    chk("post_rst_in_ready", int'(in_ready0), 1);

    // Directed vectors, including first-command latency.
    clear_logs();
    out_ready = 1'b1;
    send(0, 9, 8);
    chk("latency_edge1", int'(out_valid0), 0);
    @(posedge clk);
    #1;
    chk("latency_edge2", int'(out_valid0), 1);
    send(1, 3, 5); send(1, 5, 5); send(5, 5, 3); send(5, 3, 5);
    send(7, 0, 0); send(6, 7, 0); send(6, 6, 0); send(6, 4, 0);
    drain();
    dir0 = '{e(1,1,0,1), e(14,1,0,0), e(0,0,1,0), e(15,0,0,0), e(0,0,1,0),
             e(0,0,1,0), e(7,0,0,0), e(13,0,0,1), e(1,1,0,0)};
    dir1 = '{e(15,1,0,1), e(0,1,1,0), e(0,0,1,0), e(15,0,0,0), e(0,0,1,0),
             e(0,0,1,0), e(7,0,0,0), e(13,0,0,1), e(15,1,0,0)};
    chk("dir_count0", got0.size(), 9);
    chk("dir_count1", got1.size(), 9);
    for (int i = 0; i < 9; i++) begin
      if (got0.size() > i) chk($sformatf("dir0_%0d", i), got0[i], dir0[i]);
      if (got1.size() > i) chk($sformatf("dir1_%0d", i), got1[i], dir1[i]);
    end

    // Backpressure: third command must wait while both stages are full.
    clear_logs();
    out_ready = 1'b0;
    send(2, 12, 10);
    send(3, 12, 10);
    fork
      send(4, 12, 10);
      begin
        repeat (3) begin
          @(negedge clk);
          chk("bp_in_ready_low", int'(in_ready0), 0);
          chk("bp_hold_y", int'(y0), 8);
        end
        @(posedge clk);
        #1;
        out_ready = 1'b1;
      end
    join
    drain();
    chk("bp_count", got0.size(), 3);
    if (got0.size() == 3) begin
      chk("bp_and", got0[0], e(8, 0, 0, 0));
      chk("bp_or", got0[1], e(14, 0, 0, 0));
      chk("bp_xor", got0[2], e(6, 0, 0, 0));
    end

    // Random traffic with random consumer stalls.
    rdone = 1'b0;
    fork
      begin
        for (int i = 0; i < 1000; i++) begin
          repeat ($urandom_range(0, 2)) begin
            @(posedge clk);
            #1;
          end
          send(int'($urandom_range(0, 7)), int'($urandom_range(0, M - 1)),
               int'($urandom_range(0, M - 1)));
        end
        rdone = 1'b1;
      end
      begin
        while (!rdone) begin
          @(posedge clk);
          #1;
          out_ready = ($urandom_range(0, 3) != 0);
        end
      end
    join
    drain();

    // Reset with two commands in flight and acc = 9.
    send(7, 0, 0);
    send(6, 9, 0);
    drain();
    chk("acc_before_rst", int'(dut0.acc_q), 9);
    out_ready = 1'b0;
    send(0, 2, 3);
    send(4, 5, 6);
    #2;
    rst_n = 1'b0;
    #1;
    chk("rst_mid_out_valid0", int'(out_valid0), 0);
    chk("rst_mid_out_valid1", int'(out_valid1), 0);
    chk("rst_mid_acc0", int'(dut0.acc_q), 0);
    chk("rst_mid_acc1", int'(dut1.acc_q), 0);
    chk("rst_mid_in_ready", int'(in_ready0), 1);
    exp_q0.delete(); exp_q1.delete();
    acc_m0 = 0; acc_m1 = 0;
    clear_logs();
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b1;
    send(6, 1, 0);
    drain();
    chk("post_rst_count", got0.size(), 1);
    if (got0.size() == 1) chk("post_rst_acc0", got0[0], e(1, 0, 0, 0));
    if (got1.size() == 1) chk("post_rst_acc1", got1[0], e(1, 0, 0, 0));

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
